ssd_scan_driver: RTL

//  Board-side consumer of the datapath's 13-bit ssd debug value: converts the binary word to 4 BCD digits

---
 rtl/ssd_pkg.sv | 34 +++
 rtl/bin2bcd_seq.sv | 81 ++++++++
 rtl/ssd_scan_driver.sv | 99 +++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the 7-segment scan driver: converter FSM states,
// inactive anode/segment patterns and the digit-to-segment decode.
package ssd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  localparam int unsigned BCD_W     = 16;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [3:0]  ANODE_OFF = 4'b1111;

  // Active-low cathodes, bit order g,f,e,d,c,b,a
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, DATA_W shifts per
// conversion, result held on bcd while conv_done pulses for one cycle.
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int unsigned DATA_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_value,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [15:0]       bcd,
  output logic              conv_done
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned SR_W  = BCD_W + DATA_W;

  conv_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  sreg, sreg_adj;
  logic             last_shift;

  assign last_shift = (cnt == CNT_W'(DATA_W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (in_valid)   state_nx = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_nx = ST_DONE;
      ST_DONE:                  state_nx = ST_IDLE;
      default:                  state_nx = ST_IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that is 5 or more
  always_comb begin
    sreg_adj = sreg;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sreg[DATA_W + 4*i +: 4] >= 4'd5)
        sreg_adj[DATA_W + 4*i +: 4] = sreg[DATA_W + 4*i +: 4] + 4'd3;
    end
  end

  // Shift register and shift counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          sreg <= {{BCD_W{1'b0}}, in_value};
          cnt  <= '0;
        end
        ST_SHIFT: begin
          sreg <= sreg_adj << 1;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Handshake and completion outputs decoded from state
  always_comb begin
    in_ready  = (state == ST_IDLE);
    conv_done = (state == ST_DONE);
  end

  assign bcd = sreg[DATA_W +: BCD_W];

endmodule

// File: rtl/ssd_scan_driver.sv
// Binary-to-7-segment scan driver for a 4-digit common-anode display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero digit (ones digit always shown).
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned DATA_W      = 13,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_value,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              conv_done,
  output logic [3:0]        anode,
  output logic [6:0]        seg
);

  if (DATA_W == 0 || DATA_W > 13) begin : g_bad_data_w
    $error("ssd_scan_driver: DATA_W must be in 1..13");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("ssd_scan_driver: REFRESH_DIV must be >= 2");
  end

  localparam int unsigned RCNT_W = $clog2(REFRESH_DIV);

  logic [15:0]       conv_bcd;
  logic [15:0]       disp;
  logic [RCNT_W-1:0] rcnt;
  logic [1:0]        idx;
  logic [3:0]        cur_digit;
  logic              blank;

  bin2bcd_seq #(.DATA_W(DATA_W)) u_conv (
    .clk       (clk),
    .rst       (rst),
    .in_value  (in_value),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd       (conv_bcd),
    .conv_done (conv_done)
  );

  // Display register latches the result on the cycle the converter leaves DONE
  always_ff @(posedge clk) begin
    if (rst)            disp <= '0;
    else if (conv_done) disp <= conv_bcd;
  end

  // Refresh counter and digit index advancing on each counter wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  assign cur_digit = disp[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // Blank a slot when it and every more significant digit are zero
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd1:    blank = (disp[15:4]  == '0);
      2'd2:    blank = (disp[15:8]  == '0);
      2'd3:    blank = (disp[15:12] == '0);
      default: blank = 1'b0;
    endcase
  end
`else
  // All digits always driven
  always_comb begin
    blank = 1'b0;
  end
`endif

  // Registered anode/segment drive for the current slot
  always_ff @(posedge clk) begin
    if (rst) begin
      anode <= ANODE_OFF;
      seg   <= SEG_BLANK;
    end else if (blank) begin
      anode <= ANODE_OFF;
      seg   <= SEG_BLANK;
    end else begin
      anode <= ~(4'b0001 << idx);
      seg   <= seg_decode(cur_digit);
    end
  end

endmodule
